instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the width of the instruction-memory address and PC.
REQ-002 The block SHALL have parameter INSTR_W, default 17, meaning the instruction word width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded at reset.
REQ-004 The block SHALL use one clock, clk; reset SHALL be rst_n, asynchronous and active-low.
REQ-005 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin fetching from the current PC.
- imem_addr  out  ADDR_W  address to the combinational instruction memory.
- imem_data  in  INSTR_W  instruction returned for imem_addr in the same cycle.
- redirect_valid  in  1  branch/jump request.
- redirect_pc  in  ADDR_W  branch/jump target.
- out_valid  out  1  out_instr/out_pc hold a fetched instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  INSTR_W  fetched instruction register.
- out_pc  out  ADDR_W  address the instruction was fetched from.
- halted  out  1  high while the FSM is in HALT.

Function
REQ-006 imem_addr SHALL equal the PC register combinationally at all times.
REQ-007 The FSM SHALL have three states, IDLE, FETCH and HALT, with these transitions:
- IDLE->FETCH on start.
- FETCH->HALT when a HALT instruction is loaded.
- HALT->FETCH on redirect_valid.
REQ-008 A load SHALL occur in FETCH when (!out_valid || out_ready) and !redirect_valid, with these effects:
- out_instr<=imem_data.
- out_pc<=PC.
- out_valid<=1.
- PC<=PC+1 modulo 2^ADDR_W, so 255 wraps to 0.
REQ-009 In FETCH, when out_valid && out_ready is false and out_valid is high, out_instr, out_pc, out_valid and PC SHALL hold unchanged.
REQ-010 In FETCH, when out_ready is high and no load occurs, out_valid SHALL clear.
REQ-011 First-instruction latency: start sampled at edge k SHALL give out_valid=1 with out_pc=PC after edge k+1.
REQ-012 Redirect SHALL be defined per state:
- In FETCH or HALT, redirect_valid SHALL set PC<=redirect_pc and out_valid<=0 at the next edge, discarding any pending instruction; state SHALL go to FETCH.
- Redirect SHALL have priority over load and over stall.
- In IDLE, redirect_valid SHALL set PC<=redirect_pc and leave the state unchanged unless start is also high, in which case the state SHALL go to FETCH.
REQ-013 A load whose opcode field out_instr[INSTR_W-1:INSTR_W-5] equals HALT_OP (5'b11111) SHALL:
- enter HALT;
- not increment PC.
The HALT instruction itself SHALL be presented with out_valid=1 until accepted.
REQ-014 In HALT:
- no loads SHALL occur;
- out_valid SHALL clear when out_ready is high;
- PC SHALL hold.
REQ-015 halted SHALL equal (state==HALT).
REQ-016 start SHALL be ignored outside IDLE.

Reset
REQ-017 While rst_n=0, the block SHALL immediately force:
- state=IDLE;
- PC=RESET_PC;
- out_valid=0;
- out_instr=0;
- out_pc=0;
- halted=0.
REQ-018 Reset asserted mid-operation SHALL discard any pending instruction, with no acceptance visible afterwards.
REQ-019 After rst_n deasserts, the block SHALL remain in IDLE until start.

Structure
REQ-020 A shared package SHALL hold:
- the state encoding: IDLE=2'd0, FETCH=2'd1, HALT=2'd2;
- HALT_OP;
- the opcode field width of 5.
REQ-021 The PC SHALL be a sub-module, pc_reg, with load, increment and hold controls; everything else SHALL be in instr_fetch.
REQ-022 Instruction_Mem SHALL connect externally, with its address driven by imem_addr and its instruct output driving imem_data.

Verification
REQ-023 The bench SHALL cover these directed scenarios, as stimulus -> required response:
- Reset then start=1 for one cycle, out_ready=1, memory word i=i -> out_pc 0,1,2,… on consecutive cycles with out_instr=out_pc and no bubbles.
- out_ready=0 for 3 cycles at out_pc=4 -> out_instr and out_pc stay at 4 and PC stays 5; after release the next out_pc=5.
- redirect_valid with redirect_pc=8'h40 while out_valid=1 and out_ready=0 -> next cycle out_valid=0; the following cycle out_pc=8'h40.
- Word at address 3 = 17'h1F000 (HALT) -> out_pc=3 delivered; halted=1; no out_pc=4 ever; redirect to 0 restarts fetching.
- redirect_pc=8'hFF in a free-running fetch -> out_pc FF then 00.
- rst_n pulsed low mid-stall -> out_valid=0 immediately; PC=RESET_PC; IDLE until start.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and HALT opcode.
package instr_fetch_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam logic [OPCODE_W-1:0] HALT_OP = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: load has priority over increment, otherwise holds.
module pc_reg #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks a combinational instruction memory and presents
// one instruction at a time to decode with a valid/ready handshake.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 17,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;

  logic [ADDR_W-1:0]  w_pc;
  logic               w_load;
  logic               w_is_halt;
  logic               w_pc_inc;
  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic [ADDR_W-1:0]  r_out_pc;
  logic               r_halted;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (redirect_valid),
    .i_load_pc (redirect_pc),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc)
  );

  // Redirect outranks both load and stall; a HALT word freezes the PC on itself.
  assign w_load    = (r_state == FETCH) && (!r_out_valid || out_ready) && !redirect_valid;
  assign w_is_halt = (imem_data[INSTR_W-1 -: OPCODE_W] == HALT_OP);
  assign w_pc_inc  = w_load && !w_is_halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = FETCH;
      FETCH: begin
        if (redirect_valid)         w_next_state = FETCH;
        else if (w_load && w_is_halt) w_next_state = HALT;
      end
      HALT:    if (redirect_valid) w_next_state = FETCH;
      default: w_next_state = IDLE;
    endcase
  end

  // Output register: redirect flushes, load captures, acceptance drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_halted <= (w_next_state == HALT);
      if (redirect_valid) begin
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_instr <= imem_data;
        r_out_pc    <= w_pc;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign imem_addr = w_pc;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural instruction memory (word i = i).
module tb_instr_fetch;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 17;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               halted;

  logic [INSTR_W-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 8'h00 || out_instr !== 17'h0 || halted !== 1'b0 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: valid=%0b pc=%h instr=%h halted=%0b addr=%h, want 0 0 0 0 0",
               out_valid, out_pc, out_instr, halted, imem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: valid=%0b addr=%h, want 0 00", out_valid, imem_addr);
    end
  endtask

  task automatic test_stream();
    kick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_latency: valid=%0b one edge after start, want 0", out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'(i) || out_instr !== 17'(i)) begin
        errors++;
        $display("FAIL stream_word%0d: valid=%0b pc=%h instr=%h, want 1 %h %h",
                 i, out_valid, out_pc, out_instr, 8'(i), 17'(i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    kick();
    repeat (5) step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'h04 || out_instr !== 17'h4 || imem_addr !== 8'h05) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%0b pc=%h instr=%h addr=%h, want 1 04 00004 05",
                 i, out_valid, out_pc, out_instr, imem_addr);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'h05 || out_instr !== 17'h5) begin
      errors++;
      $display("FAIL stall_release: valid=%0b pc=%h instr=%h, want 1 05 00005", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 8'h40) begin
      errors++;
      $display("FAIL redirect_flush: valid=%0b addr=%h, want 0 40", out_valid, imem_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_instr !== 17'h40) begin
      errors++;
      $display("FAIL redirect_target: valid=%0b pc=%h instr=%h, want 1 40 00040", out_valid, out_pc, out_instr);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_pc !== 8'h41) begin
      errors++;
      $display("FAIL redirect_next: pc=%h, want 41", out_pc);
    end
  endtask

  task automatic test_halt();
    mem[3] = 17'h1F000;
    do_reset();
    kick();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_pc !== 8'(i) || halted !== 1'b0) begin
        errors++;
        $display("FAIL halt_pre%0d: pc=%h halted=%0b, want %h 0", i, out_pc, halted, 8'(i));
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'h03 || out_instr !== 17'h1F000 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_deliver: valid=%0b pc=%h instr=%h halted=%0b, want 1 03 1f000 1",
               out_valid, out_pc, out_instr, halted);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 8'h03) begin
        errors++;
        $display("FAIL halt_hold%0d: valid=%0b halted=%0b addr=%h pc=%h, want 0 1 03",
                 i, out_valid, halted, imem_addr, out_pc);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_redirect: halted=%0b valid=%0b, want 0 0", halted, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00) begin
      errors++;
      $display("FAIL halt_restart: valid=%0b pc=%h, want 1 00", out_valid, out_pc);
    end
    mem[3] = 17'h3;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'hFF || out_instr !== 17'hFF) begin
      errors++;
      $display("FAIL wrap_ff: valid=%0b pc=%h instr=%h, want 1 ff 000ff", out_valid, out_pc, out_instr);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 17'h0) begin
      errors++;
      $display("FAIL wrap_00: valid=%0b pc=%h instr=%h, want 1 00 00000", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_idle_redirect();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 8'h10 || halted !== 1'b0) begin
      errors++;
      $display("FAIL idle_redirect: valid=%0b addr=%h halted=%0b, want 0 10 0", out_valid, imem_addr, halted);
    end
    kick();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'h10) begin
      errors++;
      $display("FAIL idle_redirect_start: valid=%0b pc=%h, want 1 10", out_valid, out_pc);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 8'h00 || out_pc !== 8'h00 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%0b addr=%h pc=%h halted=%0b, want 0 00 00 0",
               out_valid, imem_addr, out_pc, halted);
    end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_stay_idle: valid=%0b addr=%h, want 0 00", out_valid, imem_addr);
    end
    kick();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_restart: valid=%0b pc=%h, want 1 00", out_valid, out_pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 17'(i);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_idle_redirect();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
